// File: rtl/usr_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// usr_cmd_sequencer
//
// Command-driven controller for a WIDTH-bit universal shift register (USR).
// Accepts one command at a time over a valid/ready handshake and sequences the
// register's mode / serial / parallel inputs cycle by cycle. The supported
// commands are parallel LOAD, serial shift right (SHR) and serial shift left
// (SHL). The block pulses done when a command completes, and pulses err as
// well for an illegal opcode.
//
// Ports
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high
//   cmd_valid  in   1      command presented
//   cmd_ready  out  1      block is IDLE and can take a command
//   cmd_op     in   2      00 LOAD, 01 SHR, 10 SHL, 11 illegal
//   cmd_data   in   WIDTH  LOAD value, or serial bit source (LSB first)
//   cmd_len    in   CNT_W  shift cycle count (ignored for LOAD)
//   usr_mode   out  2      00 hold, 01 shift right, 10 shift left, 11 load
//   usr_sil    out  1      USR serial_in_left
//   usr_sir    out  1      USR serial_in_right
//   usr_pin    out  WIDTH  USR parallel_in
//   busy       out  1      state is not IDLE
//   done       out  1      one-cycle completion pulse
//   err        out  1      one-cycle illegal-opcode pulse, coincident with done
// -----------------------------------------------------------------------------
module usr_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [1:0]       usr_mode,
    output logic             usr_sil,
    output logic             usr_sir,
    output logic [WIDTH-1:0] usr_pin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SHR    = 2'b01;
    localparam logic [1:0] OP_SHL    = 2'b10;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    // State and captured command
    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_data;
    logic [CNT_W-1:0]   r_len;

    // Registered outputs
    logic [1:0]         r_mode;
    logic               r_sil;
    logic               r_sir;
    logic [WIDTH-1:0]   r_pin;
    logic               r_done;
    logic               r_err;

    // Next-state values
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [1:0]         w_mode_nxt;
    logic               w_sil_nxt;
    logic               w_sir_nxt;
    logic [WIDTH-1:0]   w_pin_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    logic               w_accept;
    logic [WIDTH-1:0]   w_bit_src;
    logic [CNT_W-1:0]   w_bit_idx;
    logic [1:0]         w_dir_op;
    logic               w_bit;

    assign w_accept  = cmd_valid && (r_state == ST_IDLE);
    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    // Serial bit for the next shift cycle. On the accept edge the command has
    // not been captured yet, so bit 0 comes straight from the inputs; inside
    // SHIFT it is bit r_cnt+1 of the captured data. A one-hot mask shifted
    // past the MSB becomes all zeros, which gives data[k]=0 for k >= WIDTH.
    assign w_bit_src = (r_state == ST_IDLE) ? cmd_data : r_data;
    assign w_bit_idx = (r_state == ST_IDLE) ? '0 : r_cnt + 1'b1;
    assign w_dir_op  = (r_state == ST_IDLE) ? cmd_op : r_op;
    assign w_bit     = |(w_bit_src & (ONE_HOT0 << w_bit_idx));

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = MODE_HOLD;
        w_sil_nxt   = 1'b0;
        w_sir_nxt   = 1'b0;
        w_pin_nxt   = '0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    unique case (cmd_op)
                        OP_LOAD: begin
                            w_state_nxt = ST_LOAD;
                            w_mode_nxt  = MODE_LOAD;
                            w_pin_nxt   = cmd_data;
                        end
                        OP_SHR, OP_SHL: begin
                            if (cmd_len == '0) begin
                                w_state_nxt = ST_DONE;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_state_nxt = ST_SHIFT;
                                w_cnt_nxt   = '0;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_DONE;
                            w_done_nxt  = 1'b1;
                            w_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end
            ST_LOAD: begin
                w_state_nxt = ST_DONE;
                w_done_nxt  = 1'b1;
            end
            ST_SHIFT: begin
                // r_len >= 1 here, so r_len-1 never underflows and the counter
                // stops before it could wrap.
                if (r_cnt == r_len - 1'b1) begin
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Drive the active serial line for any cycle that will be a shift.
        if (w_state_nxt == ST_SHIFT) begin
            if (w_dir_op == OP_SHL) begin
                w_mode_nxt = MODE_SHL;
                w_sil_nxt  = w_bit;
            end else begin
                w_mode_nxt = MODE_SHR;
                w_sir_nxt  = w_bit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_len   <= '0;
            r_mode  <= MODE_HOLD;
            r_sil   <= 1'b0;
            r_sir   <= 1'b0;
            r_pin   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // the pre-edge values regardless of statement order.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_sil   <= w_sil_nxt;
            r_sir   <= w_sir_nxt;
            r_pin   <= w_pin_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_len  <= cmd_len;
            end
        end
    end

    assign usr_mode = r_mode;
    assign usr_sil  = r_sil;
    assign usr_sir  = r_sir;
    assign usr_pin  = r_pin;
    assign done     = r_done;
    assign err      = r_err;

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_usr_cmd_sequencer
//
// Directed bench for usr_cmd_sequencer (WIDTH=4, CNT_W=3). A small model of
// the downstream universal shift register is driven by the DUT outputs so the
// resulting register contents can be compared with hand-computed values.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_usr_cmd_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk;
    logic             reset;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;
    logic [1:0]       usr_mode;
    logic             usr_sil;
    logic             usr_sir;
    logic [WIDTH-1:0] usr_pin;
    logic             busy;
    logic             done;
    logic             err;

    logic [WIDTH-1:0] usr_q;

    int n_checks = 0;
    int n_pass   = 0;

    usr_cmd_sequencer #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .usr_mode  (usr_mode),
        .usr_sil   (usr_sil),
        .usr_sir   (usr_sir),
        .usr_pin   (usr_pin),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream register: SHR inserts serial_in_right at the MSB,
    // SHL inserts serial_in_left at the LSB.
    always_ff @(posedge clk) begin
        case (usr_mode)
            2'b11:   usr_q <= usr_pin;
            2'b01:   usr_q <= {usr_sir, usr_q[WIDTH-1:1]};
            2'b10:   usr_q <= {usr_q[WIDTH-2:0], usr_sil};
            default: usr_q <= usr_q;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [1:0] op, input logic [3:0] data, input logic [2:0] len);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
    endtask

    bit shr_exp [4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    bit shl_exp [7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int done_seen;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        cmd_len   = '0;
        usr_q     = '0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_mode",  usr_mode,  2'b00);
        check("rst_busy",  busy,      1'b0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_done",  done,      1'b0);
        check("rst_err",   err,       1'b0);
        check("rst_pin",   usr_pin,   4'b0000);
        reset = 1'b0;

        // LOAD 1011
        present(2'b00, 4'b1011, 3'd0);
        tick();                       // T+1
        cmd_valid = 1'b0;
        check("ld_mode",  usr_mode,  2'b11);
        check("ld_pin",   usr_pin,   4'b1011);
        check("ld_busy",  busy,      1'b1);
        check("ld_ready", cmd_ready, 1'b0);
        check("ld_done0", done,      1'b0);
        tick();                       // T+2
        check("ld_done",  done,      1'b1);
        check("ld_mode2", usr_mode,  2'b00);
        check("ld_q",     usr_q,     4'b1011);
        tick();                       // T+3
        check("ld_done1", done,      1'b0);
        check("ld_rdy3",  cmd_ready, 1'b1);

        // SHR data=1011 len=4
        present(2'b01, 4'b1011, 3'd4);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("shr_mode", usr_mode, 2'b01);
            check("shr_sir",  usr_sir,  shr_exp[k]);
            check("shr_sil",  usr_sil,  1'b0);
            check("shr_busy", busy,     1'b1);
            check("shr_done", done,     1'b0);
            tick();
        end
        check("shr_done5", done,     1'b1);
        check("shr_busy5", busy,     1'b1);
        check("shr_mode5", usr_mode, 2'b00);
        tick();
        check("shr_idle",  busy,     1'b0);
        check("shr_q",     usr_q,    4'b1011);

        // SHL data=0110 len=7
        present(2'b10, 4'b0110, 3'd7);
        tick();
        cmd_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("shl_mode", usr_mode, 2'b10);
            check("shl_sil",  usr_sil,  shl_exp[k]);
            check("shl_sir",  usr_sir,  1'b0);
            check("shl_done", done,     1'b0);
            tick();
        end
        check("shl_done8", done,      1'b1);
        tick();
        check("shl_rdy9",  cmd_ready, 1'b1);
        check("shl_q",     usr_q,     4'b0000);

        // SHR len=0
        present(2'b01, 4'b1111, 3'd0);
        tick();
        cmd_valid = 1'b0;
        check("len0_done", done,     1'b1);
        check("len0_err",  err,      1'b0);
        check("len0_mode", usr_mode, 2'b00);
        tick();
        check("len0_rdy",  cmd_ready, 1'b1);

        // Illegal opcode
        present(2'b11, 4'b1111, 3'd3);
        tick();
        cmd_valid = 1'b0;
        check("ill_done", done,     1'b1);
        check("ill_err",  err,      1'b1);
        check("ill_mode", usr_mode, 2'b00);
        check("ill_sir",  usr_sir,  1'b0);
        tick();
        check("ill_err1", err,       1'b0);
        check("ill_rdy",  cmd_ready, 1'b1);

        // Reset during shift cycle 3 of SHR 1111 len=6
        present(2'b01, 4'b1111, 3'd6);
        tick();                       // shift cycle 0
        cmd_valid = 1'b0;
        check("ab_mode0", usr_mode, 2'b01);
        tick();                       // cycle 1
        tick();                       // cycle 2
        tick();                       // cycle 3
        check("ab_sir3",  usr_sir,  1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("ab_mode",  usr_mode,  2'b00);
        check("ab_busy",  busy,      1'b0);
        check("ab_ready", cmd_ready, 1'b1);
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) done_seen++;
            tick();
        end
        check("ab_nodone", done_seen, 0);

        // Busy handshake: valid held with a second command during SHR len=2
        present(2'b01, 4'b0011, 3'd2);
        tick();                       // accept1 + 1
        present(2'b10, 4'b0101, 3'd3);
        check("hs_sir0",  usr_sir,   1'b1);
        check("hs_rdy1",  cmd_ready, 1'b0);
        tick();                       // +2
        check("hs_sir1",  usr_sir,   1'b1);
        check("hs_mode1", usr_mode,  2'b01);
        tick();                       // +3
        check("hs_done",  done,      1'b1);
        check("hs_rdy3",  cmd_ready, 1'b0);
        tick();                       // +4: second command accepted at end
        check("hs_rdy4",  cmd_ready, 1'b1);
        check("hs_mode4", usr_mode,  2'b00);
        tick();                       // second cmd, shift cycle 0
        cmd_valid = 1'b0;
        check("hs2_mode", usr_mode,  2'b10);
        check("hs2_sil0", usr_sil,   1'b1);
        tick();
        check("hs2_sil1", usr_sil,   1'b0);
        tick();
        check("hs2_sil2", usr_sil,   1'b1);
        tick();
        check("hs2_done", done,      1'b1);
        tick();
        check("hs2_idle", busy,      1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/usr_cmd_sequencer.md
# usr_cmd_sequencer

Command-driven controller that sits directly upstream of the 4-bit universal shift register and drives its `mode`, `serial_in_left`, `serial_in_right` and `parallel_in` inputs. It accepts one command at a time over a valid/ready handshake: parallel load, multi-cycle serial shift-right, or multi-cycle serial shift-left. It then sequences the register cycle by cycle and pulses `done` when the command completes. Software-level traffic and the self-test FSM use it instead of toggling register controls directly.

## Interface
- `WIDTH`, default 4: data width; matches the shift register.
- `CNT_W`, default 3: shift-count width; maximum shift length is 2^CNT_W−1.

- `clk` — in, 1 — single clock; all logic is sampled on the rising edge.
- `reset` — in, 1 — synchronous, active-high.
- `cmd_valid` — in, 1 — a command is presented.
- `cmd_ready` — out, 1 — the block can accept a command.
- `cmd_op` — in, 2 — command opcode:
  - 00: LOAD.
  - 01: SHR (shift right).
  - 10: SHL (shift left).
  - 11: illegal.
- `cmd_data` — in, WIDTH — LOAD value, or the serial bit source for shifts.
- `cmd_len` — in, CNT_W — number of shift cycles; ignored for LOAD.
- `usr_mode` — out, 2 — shift register mode:
  - 00: hold.
  - 01: shift right, new bit taken from `serial_in_right`.
  - 10: shift left, new bit taken from `serial_in_left`.
  - 11: parallel load.
- `usr_sil` — out, 1 — drives `serial_in_left`.
- `usr_sir` — out, 1 — drives `serial_in_right`.
- `usr_pin` — out, WIDTH — drives `parallel_in`.
- `busy` — out, 1 — high whenever the state is not IDLE.
- `done` — out, 1 — one-cycle completion pulse.
- `err` — out, 1 — one-cycle pulse, coincident with `done`, for an illegal opcode.

## Operation
- **States:** IDLE, LOAD, SHIFT, DONE. All USR-facing outputs and `done`/`err` are registered.
- **Outputs per state:**
  - IDLE and DONE: `usr_mode`=00, `usr_sil`=`usr_sir`=0, `usr_pin`=0.
  - `cmd_ready` = (state==IDLE); it is combinational from the state register.
- **Accept:** a command is accepted on a rising edge with `cmd_valid && cmd_ready && !reset`. At that edge `cmd_op`, `cmd_data` and `cmd_len` are captured into internal registers. Later input changes have no effect.
- **IDLE → LOAD** (op 00):
  - LOAD lasts exactly 1 cycle: `usr_mode`=11, `usr_pin`=captured data.
  - Then LOAD → DONE.
- **IDLE → SHIFT** (op 01/10, len ≥ 1):
  - SHIFT lasts exactly `len` cycles, with `usr_mode`=01 (SHR) or 10 (SHL).
  - On shift cycle k (k=0..len−1), the active serial line carries data[k]: LSB first, data[k]=0 for k ≥ WIDTH. The active line is `usr_sir` for SHR and `usr_sil` for SHL.
  - The inactive serial line is held at 0. `usr_pin` is held at 0.
  - Then SHIFT → DONE.
- **IDLE → DONE directly:** op 01/10 with len = 0 (no shift cycles), or op 11 (`err`=1).
- **DONE:** lasts 1 cycle with `done`=1, then → IDLE.
- **Internal counter:** counts shift cycles; it is CNT_W bits wide and never wraps, because the exit condition is compare-equal to len−1.
- **Reset:**
  - When `reset`=1 at an edge: state→IDLE; `usr_mode`=00, `usr_sil`=`usr_sir`=0, `usr_pin`=0, `done`=0, `err`=0, `busy`=0; counter and captured command cleared.
  - Reset mid-LOAD or mid-SHIFT aborts the command immediately with no `done` pulse.
  - Reset wins over a simultaneous accept.
- `cmd_valid` while busy is ignored; it is not queued.

## Timing
- Accept at edge T. First USR control cycle is T+1.
- **LOAD:** `usr_mode`=11 during T+1; `done` during T+2; `cmd_ready`=1 again in T+3.
- **SHIFT with length n:** `usr_mode` active during T+1..T+n; `done` during T+n+1; next accept possible at the end of T+n+2.
- **len=0 or illegal op:** `done` (and `err` for the illegal op) during T+1.
- Back-to-back commands: the minimum spacing between accepts is n+2 cycles for shifts and 3 cycles for LOAD.
- The USR samples the outputs on the same `clk` edge that ends each cycle. Each control value is therefore applied to exactly one register update.

## Test plan
- **Reset then LOAD:** reset held 2 cycles, then LOAD with data=1011.
  - One cycle with `usr_mode`=11, `usr_pin`=1011, followed by `done`=1 for one cycle.
  - Downstream q=1011 after that cycle.
- **SHR:** data=1011, len=4.
  - `usr_mode`=01 for 4 cycles, with `usr_sir` = 1,1,0,1 and `usr_sil`=0 throughout.
  - `done` 5 cycles after accept; `busy` high for 5 cycles.
- **SHL:** data=0110, len=7.
  - `usr_sil` = 0,1,1,0,0,0,0 over 7 cycles with `usr_mode`=10.
  - `done` at accept+8; no counter wrap.
- **Edge commands:**
  - SHR with len=0 gives `done` at accept+1 and `usr_mode` stays 00.
  - op=11 gives `done`=`err`=1 at accept+1 with no USR activity.
- **Reset mid-SHIFT:** SHR data=1111, len=6, with reset asserted in shift cycle 3.
  - The next cycle shows `usr_mode`=00, `busy`=0, `cmd_ready`=1, and there is no `done` pulse.
- **Busy handshake:** `cmd_valid` held high with a second command throughout a first SHR (len=2).
  - The second command is accepted only when `cmd_ready`=1, at accept1+4, and executes with its own data.
